// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock parametrised FIFO with first-word-fall-through
// output. The head of the queue is kept in a register (rd_d) so there is no
// combinational path from the storage array to the output. Occupancy,
// almost-full/almost-empty and sticky error flags are all registered and
// computed from next-state values, so they are exact one cycle after the edge.
//
// Handshake semantics: a write is accepted on a rising edge when
// wr_en=1 and wr_full=0; a read is accepted when rd_en=1 and rd_empty=0 and
// consumes the word presented on rd_d during that cycle. Requests made while
// full/empty are rejected without side effects other than the sticky flags.
module sync_fifo_param #(
  parameter int WIDTH    = 8,
  parameter int ADDR_W   = 12,
  parameter int AF_LEVEL = (1 << ADDR_W) - 4,
  parameter int AE_LEVEL = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  wr_d,
  input  logic              wr_en,
  output logic              wr_full,
  output logic              wr_almost_full,
  output logic [WIDTH-1:0]  rd_d,
  input  logic              rd_en,
  output logic              rd_empty,
  output logic              rd_almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              err_ovf,
  output logic              err_udf,
  input  logic              err_clr
);

  localparam int              DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] AF_C  = AF_LEVEL[ADDR_W:0];
  localparam logic [ADDR_W:0] AE_C  = AE_LEVEL[ADDR_W:0];
  localparam logic [ADDR_W:0] ONE_C = {{ADDR_W{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];

  // Pointers carry one extra wrap bit above the address bits.
  logic [ADDR_W:0]  wr_ptr;
  logic [ADDR_W:0]  rd_ptr;
  logic [ADDR_W:0]  wr_ptr_nxt;
  logic [ADDR_W:0]  rd_ptr_nxt;
  logic [ADDR_W:0]  count_nxt;
  logic             full_nxt;
  logic             empty_nxt;
  logic             wr_acc;
  logic             rd_acc;
  logic             bypass;
  logic [WIDTH-1:0] head_nxt;

  assign wr_acc = wr_en & ~wr_full;
  assign rd_acc = rd_en & ~rd_empty;

  // Next pointers, occupancy, full/empty and the next head-of-queue word.
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;
    if (wr_acc) wr_ptr_nxt = wr_ptr + ONE_C;
    if (rd_acc) rd_ptr_nxt = rd_ptr + ONE_C;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + ONE_C;
      2'b01:   count_nxt = count - ONE_C;
      default: count_nxt = count;
    endcase
    full_nxt  = (wr_ptr_nxt[ADDR_W-1:0] == rd_ptr_nxt[ADDR_W-1:0]) &&
                (wr_ptr_nxt[ADDR_W] != rd_ptr_nxt[ADDR_W]);
    empty_nxt = (wr_ptr_nxt == rd_ptr_nxt);
    // When the next head slot is the one being written this very cycle
    // (FIFO becoming a single-entry queue), take the word straight from wr_d.
    bypass    = wr_acc && (wr_ptr == rd_ptr_nxt);
    head_nxt  = bypass ? wr_d : mem[rd_ptr_nxt[ADDR_W-1:0]];
  end

  // Storage array: written on accepted writes, never reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr[ADDR_W-1:0]] <= wr_d;
  end

  // Pointers, occupancy, flags and head register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      wr_full         <= 1'b0;
      rd_empty        <= 1'b1;
      wr_almost_full  <= (AF_LEVEL == 0);
      rd_almost_empty <= 1'b1;
      err_ovf         <= 1'b0;
      err_udf         <= 1'b0;
      rd_d            <= '0;
    end else begin
      wr_ptr          <= wr_ptr_nxt;
      rd_ptr          <= rd_ptr_nxt;
      count           <= count_nxt;
      wr_full         <= full_nxt;
      rd_empty        <= empty_nxt;
      wr_almost_full  <= (count_nxt >= AF_C);
      rd_almost_empty <= (count_nxt <= AE_C);
      // A new error in the same cycle as err_clr keeps the flag set.
      err_ovf         <= (wr_en & wr_full) | (err_ovf & ~err_clr);
      err_udf         <= (rd_en & rd_empty) | (err_udf & ~err_clr);
      // Head holds its last value while the FIFO is empty.
      if (!empty_nxt) rd_d <= head_nxt;
    end
  end

endmodule
